// File: rtl/bfly_pair_stage.sv
// rtl/bfly_pair_stage.sv - radix-2 butterfly pairing consecutive complex vectors
//
// Pairs consecutive accepted input vectors as operands A and B and registers
// per-lane sign-extended sums and differences for the downstream saturation
// stage.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   din_valid   input vector valid this cycle
//   sync        frame resync: the current/next accepted vector becomes A
//   din_R/Q     DEPTH lanes x DIN_WIDTH signed, lane i at [i*DIN_WIDTH +: DIN_WIDTH]
//   dout_valid  registered results valid (drives saturation en)
//   dout_R_add/R_sub/Q_add/Q_sub  DEPTH lanes x WIDTH signed results
//   pair_drop   one-cycle pulse when a held A operand is discarded by sync
//   pair_cnt    emitted-pair count, wraps modulo 2^CNT_WIDTH
module bfly_pair_stage #(
  parameter int DIN_WIDTH = 13,
  parameter int WIDTH     = 14,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       din_valid,
  input  logic                       sync,
  input  logic [DEPTH*DIN_WIDTH-1:0] din_R,
  input  logic [DEPTH*DIN_WIDTH-1:0] din_Q,
  output logic                       dout_valid,
  output logic [DEPTH*WIDTH-1:0]     dout_R_add,
  output logic [DEPTH*WIDTH-1:0]     dout_R_sub,
  output logic [DEPTH*WIDTH-1:0]     dout_Q_add,
  output logic [DEPTH*WIDTH-1:0]     dout_Q_sub,
  output logic                       pair_drop,
  output logic [CNT_WIDTH-1:0]       pair_cnt
);

  typedef enum logic {
    WAIT_A = 1'b0,
    WAIT_B = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   capture_a;
  logic   emit;
  logic   drop;

  logic [DEPTH*DIN_WIDTH-1:0] a_R;
  logic [DEPTH*DIN_WIDTH-1:0] a_Q;

  logic [DEPTH*WIDTH-1:0] r_add, r_sub, q_add, q_sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_A;
    end else begin
      state <= state_nxt;
    end
  end

  // sync takes priority over pairing: a vector arriving with sync always
  // starts a new pair instead of completing the held one.
  always_comb begin
    state_nxt = state;
    capture_a = 1'b0;
    emit      = 1'b0;
    drop      = 1'b0;
    case (state)
      WAIT_A: begin
        if (din_valid) begin
          capture_a = 1'b1;
          state_nxt = WAIT_B;
        end
      end
      WAIT_B: begin
        if (sync) begin
          drop = 1'b1;
          if (din_valid) begin
            capture_a = 1'b1;
            state_nxt = WAIT_B;
          end else begin
            state_nxt = WAIT_A;
          end
        end else if (din_valid) begin
          emit      = 1'b1;
          state_nxt = WAIT_A;
        end
      end
      default: begin
        state_nxt = WAIT_A;
      end
    endcase
  end

  // One extra bit of headroom means neither sum nor difference can overflow.
  for (genvar i = 0; i < DEPTH; i++) begin : g_lane
    logic [DIN_WIDTH-1:0] ar, aq, br, bq;
    logic [WIDTH-1:0]     ar_x, aq_x, br_x, bq_x;
    assign ar   = a_R[i*DIN_WIDTH +: DIN_WIDTH];
    assign aq   = a_Q[i*DIN_WIDTH +: DIN_WIDTH];
    assign br   = din_R[i*DIN_WIDTH +: DIN_WIDTH];
    assign bq   = din_Q[i*DIN_WIDTH +: DIN_WIDTH];
    assign ar_x = {{(WIDTH-DIN_WIDTH){ar[DIN_WIDTH-1]}}, ar};
    assign aq_x = {{(WIDTH-DIN_WIDTH){aq[DIN_WIDTH-1]}}, aq};
    assign br_x = {{(WIDTH-DIN_WIDTH){br[DIN_WIDTH-1]}}, br};
    assign bq_x = {{(WIDTH-DIN_WIDTH){bq[DIN_WIDTH-1]}}, bq};
    assign r_add[i*WIDTH +: WIDTH] = ar_x + br_x;
    assign r_sub[i*WIDTH +: WIDTH] = ar_x - br_x;
    assign q_add[i*WIDTH +: WIDTH] = aq_x + bq_x;
    assign q_sub[i*WIDTH +: WIDTH] = aq_x - bq_x;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_R        <= '0;
      a_Q        <= '0;
      dout_valid <= 1'b0;
      dout_R_add <= '0;
      dout_R_sub <= '0;
      dout_Q_add <= '0;
      dout_Q_sub <= '0;
      pair_drop  <= 1'b0;
      pair_cnt   <= '0;
    end else begin
      dout_valid <= emit;
      pair_drop  <= drop;
      if (capture_a) begin
        a_R <= din_R;
        a_Q <= din_Q;
      end
      // Results hold between pairs so the downstream stage sees stable data.
      if (emit) begin
        dout_R_add <= r_add;
        dout_R_sub <= r_sub;
        dout_Q_add <= q_add;
        dout_Q_sub <= q_sub;
        pair_cnt   <= pair_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/bfly_pair_stage.md
Name: bfly_pair_stage

Overview:
Radix-2 butterfly stage that sits directly upstream of the saturation stage. It accepts a stream of DEPTH-wide vectors of complex 13-bit samples (R/Q) and pairs consecutive vectors as operands A and B. It produces registered, sign-extended 14-bit sum and difference vectors (R_add, R_sub, Q_add, Q_sub). Its dout_valid drives the saturation stage's en, and its 14-bit outputs drive that stage's din_* arrays.

Parameters:
DIN_WIDTH, 13, input sample width (signed, two's complement)
WIDTH, 14, output width; must equal DIN_WIDTH+1 (saturation stage input width)
DEPTH, 4, lanes per vector (matches saturation DEPTH)
CNT_WIDTH, 16, width of the emitted-pair counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
din_valid  input  1  input vector valid this cycle
sync  input  1  frame resync; the current/next accepted vector becomes operand A
din_R  input  DEPTH x DIN_WIDTH signed  real-part input vector
din_Q  input  DEPTH x DIN_WIDTH signed  imaginary-part input vector
dout_valid  output  1  output vector valid (connects to saturation en)
dout_R_add  output  DEPTH x WIDTH signed  A_R + B_R per lane
dout_R_sub  output  DEPTH x WIDTH signed  A_R - B_R per lane
dout_Q_add  output  DEPTH x WIDTH signed  A_Q + B_Q per lane
dout_Q_sub  output  DEPTH x WIDTH signed  A_Q - B_Q per lane
pair_drop  output  1  one-cycle pulse: a held A operand was discarded by sync
pair_cnt  output  CNT_WIDTH  number of emitted pairs, modulo 2^CNT_WIDTH

Behaviour:
- Reset (async assert, sync-to-clk release): state=WAIT_A; A registers=0; all dout_* =0; dout_valid=0; pair_drop=0; pair_cnt=0.
- FSM states: WAIT_A (no operand held), WAIT_B (A held).
- WAIT_A, din_valid=1: capture din_R/din_Q into the A registers -> WAIT_B. dout_valid=0 next cycle.
- WAIT_B, din_valid=1, sync=0: compute outputs from held A and current din (as B); register them; dout_valid=1 next cycle; pair_cnt+1 (wraps) -> WAIT_A.
- din_valid=0 (either state): state and A hold; dout_valid=0 next cycle; dout_* hold last values.
- sync=1 with din_valid=1:
  - Current vector is captured as the new A -> WAIT_B; no output is produced.
  - If the state was WAIT_B, pair_drop=1 next cycle.
- sync=1 with din_valid=0:
  - State -> WAIT_A; the held A is discarded.
  - If the state was WAIT_B, pair_drop=1 next cycle.
- pair_drop is high for exactly one cycle per discard event; it is 0 otherwise.
- Arithmetic: operands are sign-extended to WIDTH before add/sub. No saturation or wrap occurs in this block.
  - Max sum = 8190; min sum = -8192.
  - Difference range is -8191..8191.
  - All results fit in 14 bits; range limiting to 13 bits is the downstream stage's job.
- Latency: one clock from acceptance of B to dout_valid=1 with results.
- Throughput: one output vector per two accepted input vectors. Back-to-back din_valid is supported with no bubbles required.
- All lanes are processed in parallel and independently; lane i of A pairs only with lane i of B.
- Reset mid-pair: the held A is discarded with no pair_drop pulse, and the FSM starts from WAIT_A.

Test Plan:
1. Reset, then A lane0 R=3000, B lane0 R=1000 on consecutive cycles. Required: one cycle after B, dout_valid=1, R_add[0]=4000, R_sub[0]=2000, pair_cnt=1.
2. Extremes across lanes:
   - A R={4095,-4096,-4096,0}, B R={4095,-4096,4095,-1}.
   - Required: R_add={8190,-8192,-1,-1} and R_sub={0,0,-8191,1}.
   - Q lanes are checked with the same values.
3. Gaps: A, then din_valid=0 for 3 cycles, then B. Required: dout_valid=0 during the gap and exactly one pulse after B; dout_* unchanged before that pulse.
4. Sync while A is held: accept A1=100, then sync=1 with din_valid=1 and value 200, then B=50. Required: pair_drop pulses once; output R_add=250, R_sub=150.
5. Async reset mid-pair: accept A, then assert rst_n=0 between clock edges. Required: outputs go to 0 immediately; after release, the next two vectors pair correctly; pair_cnt restarts at 0.
6. Counter wrap: run 2^CNT_WIDTH pairs, or a reduced-CNT_WIDTH build with CNT_WIDTH=4 and 16 pairs. Required: pair_cnt wraps to 0; results stay correct.
